spi_cfg_write_sched: RTL and testbench



---
 rtl/spi_cfg_write_sched_if.sv | 36 +++
 rtl/spi_cfg_write_sched.sv | 106 ++++++++++
 tb/tb_spi_cfg_write_sched.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_cfg_write_sched_if.sv
// Requester handshakes plus the configuration SPI bus of spi_cfg_write_sched.
//   master : requester/bus-observer side (drives valid/addr/data).
//   slave  : scheduler side (drives ready, nCS/COPI and status).
// Signals:
//   reqN_valid/addr[6:0]/data[7:0]/ready : per-requester write command handshake.
//   nCS, COPI                            : serial frame select (active-low) and data.
//   busy, err_addr, last_grant           : scheduler status.
interface spi_cfg_write_sched_if;
    logic       req0_valid;
    logic [6:0] req0_addr;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [6:0] req1_addr;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       nCS;
    logic       COPI;
    logic       busy;
    logic       err_addr;
    logic       last_grant;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  nCS, COPI, busy, err_addr, last_grant
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output nCS, COPI, busy, err_addr, last_grant
    );
endinterface

// File: rtl/spi_cfg_write_sched.sv
// Two-requester round-robin scheduler that serializes register writes onto
// the configuration SPI bus as 16-bit frames {1, addr[6:0], data[7:0]},
// MSB first, followed by an nCS-high gap of GAP_CYCLES cycles.
// Commands addressed above MAX_ADDR are consumed, flagged on err_addr and
// never reach the bus.
// Ports:
//   SCLK  : clock, all state on posedge.
//   rst_n : asynchronous active-low reset.
//   bus   : spi_cfg_write_sched_if.slave (requester handshakes, nCS/COPI,
//           busy, err_addr, last_grant).
module spi_cfg_write_sched #(
    parameter int MAX_ADDR   = 4,
    parameter int GAP_CYCLES = 2
) (
    input logic                  SCLK,
    input logic                  rst_n,
    spi_cfg_write_sched_if.slave bus
);

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} state_t;

    state_t      state, state_nxt;
    logic [14:0] shreg;      // bits 14..0 of the frame; bit 15 goes out at acceptance
    logic [3:0]  bit_cnt;
    logic [3:0]  gap_cnt;
    logic        ncs_q, copi_q, err_q, last_q;
    logic        winner, accept, addr_bad;
    logic [6:0]  win_addr;
    logic [7:0]  win_data;

    // Round-robin: on contention the requester that did not win last time goes.
    always_comb begin
        winner = 1'b0;
        if (bus.req0_valid && bus.req1_valid) winner = ~last_q;
        else if (bus.req1_valid)              winner = 1'b1;
        accept   = (state == IDLE) && (bus.req0_valid || bus.req1_valid);
        win_addr = winner ? bus.req1_addr : bus.req0_addr;
        win_data = winner ? bus.req1_data : bus.req0_data;
        addr_bad = win_addr > 7'(MAX_ADDR);
    end

    assign bus.req0_ready = accept && !winner;
    assign bus.req1_ready = accept &&  winner;
    assign bus.nCS        = ncs_q;
    assign bus.COPI       = copi_q;
    assign bus.busy       = (state != IDLE);
    assign bus.err_addr   = err_q;
    assign bus.last_grant = last_q;

    // The IDLE cycle in which the next command is granted is itself the last
    // nCS-high gap cycle, so GAP dwells GAP_CYCLES-1 cycles (none for 1).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !addr_bad) state_nxt = SHIFT;
            SHIFT:   if (bit_cnt == 4'd0) state_nxt = (GAP_CYCLES > 1) ? GAP : IDLE;
            GAP:     if (gap_cnt == 4'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge SCLK or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            ncs_q   <= 1'b1;
            copi_q  <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state <= state_nxt;
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        last_q <= winner;
                        if (addr_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            shreg   <= {win_addr, win_data};
                            ncs_q   <= 1'b0;
                            copi_q  <= 1'b1;
                            bit_cnt <= 4'd15;
                        end
                    end
                end
                SHIFT: begin
                    if (bit_cnt != 4'd0) begin
                        copi_q  <= shreg[14];
                        shreg   <= {shreg[13:0], 1'b0};
                        bit_cnt <= bit_cnt - 4'd1;
                    end else begin
                        ncs_q   <= 1'b1;
                        copi_q  <= 1'b0;
                        gap_cnt <= 4'(GAP_CYCLES - 1);
                    end
                end
                GAP:     gap_cnt <= gap_cnt - 4'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cfg_write_sched.sv
// Self-checking bench for spi_cfg_write_sched: a reference model predicts
// grants and frames, pushes them into a scoreboard queue, and a bus monitor
// deserializes nCS/COPI frames and err_addr pulses and compares them.
// A second instance built with GAP_CYCLES=1 is checked for frame spacing.
module tb_spi_cfg_write_sched;
    localparam int MAX_ADDR = 4;
    localparam int GAP      = 2;

    typedef enum {M_RAND, M_HOLD, M_DROP, M_CONT} mode_t;
    typedef struct {bit is_err; logic [15:0] frame; int edge_n;} exp_t;

    logic SCLK = 1'b0;
    logic rst_n, rst1_n;
    always #5 SCLK = ~SCLK;

    spi_cfg_write_sched_if bus();
    spi_cfg_write_sched_if bus1();

    spi_cfg_write_sched #(.MAX_ADDR(MAX_ADDR), .GAP_CYCLES(GAP)) dut (
        .SCLK(SCLK), .rst_n(rst_n), .bus(bus));
    spi_cfg_write_sched #(.MAX_ADDR(MAX_ADDR), .GAP_CYCLES(1)) dut1 (
        .SCLK(SCLK), .rst_n(rst1_n), .bus(bus1));

    int    vectors = 0, miscompares = 0;
    int    cyc = 0;
    exp_t  exp_q[$];
    int    m_free = 0;
    bit    m_last = 1'b1;
    int    m_err_edge = -10;
    mode_t mode = M_DROP;
    logic [15:0] last_frame = '0;

    always @(posedge SCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_req(input bit r, input bit v, input logic [6:0] a, input logic [7:0] d);
        if (r) begin bus.req1_valid = v; bus.req1_addr = a; bus.req1_data = d; end
        else   begin bus.req0_valid = v; bus.req0_addr = a; bus.req0_data = d; end
    endtask

    task automatic new_cmd(input bit r, input bit legal_only);
        logic [6:0] a;
        if (!legal_only && $urandom_range(0, 3) == 0) a = 7'($urandom_range(MAX_ADDR + 1, 127));
        else                                          a = 7'($urandom_range(0, MAX_ADDR));
        set_req(r, 1'b1, a, 8'($urandom));
    endtask

    // One cycle: check outputs and predict the decision for the next edge at
    // the negedge, then change requester inputs just after that edge.
    task automatic step();
        bit idle, w, v0, v1, acc;
        logic [6:0] a;
        logic [7:0] d;
        @(negedge SCLK);
        idle = (cyc + 1 >= m_free);
        v0 = bus.req0_valid;
        v1 = bus.req1_valid;
        chk("busy", bus.busy, !idle);
        chk("last_grant", bus.last_grant, m_last);
        chk("err_addr", bus.err_addr, cyc == m_err_edge);
        w = (v0 && v1) ? !m_last : v1;
        chk("req0_ready", bus.req0_ready, idle && v0 && !w);
        chk("req1_ready", bus.req1_ready, idle && v1 && w);
        acc = idle && (v0 || v1);
        if (acc) begin
            m_last = w;
            a = w ? bus.req1_addr : bus.req0_addr;
            d = w ? bus.req1_data : bus.req0_data;
            if (a > 7'(MAX_ADDR)) begin
                m_err_edge = cyc + 1;
                m_free     = cyc + 2;
                exp_q.push_back('{1'b1, 16'h0, cyc + 1});
            end else begin
                m_free = cyc + 1 + 16 + GAP;
                exp_q.push_back('{1'b0, {1'b1, a, d}, cyc + 1});
            end
        end
        @(posedge SCLK);
        #1;
        if (acc) begin
            case (mode)
                M_DROP: set_req(w, 1'b0, 7'd0, 8'd0);
                M_CONT: new_cmd(w, 1'b1);
                M_RAND: if ($urandom_range(0, 3) != 0) new_cmd(w, 1'b0);
                        else set_req(w, 1'b0, 7'd0, 8'd0);
                default: ;
            endcase
        end
        if (mode == M_RAND) begin
            if (!bus.req0_valid && $urandom_range(0, 2) == 0) new_cmd(1'b0, 1'b0);
            if (!bus.req1_valid && $urandom_range(0, 2) == 0) new_cmd(1'b1, 1'b0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_nCS", bus.nCS, 1'b1);
        chk("rst_COPI", bus.COPI, 1'b0);
        chk("rst_err_addr", bus.err_addr, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_last_grant", bus.last_grant, 1'b1);
        exp_q.delete();
        m_free     = 0;
        m_last     = 1'b1;
        m_err_edge = -10;
        @(posedge SCLK);
        #1;
        rst_n = 1'b1;
    endtask

    // Bus monitor: rebuilds frames from nCS/COPI and pops the scoreboard.
    int          mon_bits = 0, mon_start = 0;
    logic [15:0] mon_acc = '0;
    exp_t        mon_e;
    always @(negedge SCLK) begin
        if (!rst_n) begin
            mon_bits = 0;
        end else begin
            if (bus.err_addr) begin
                if (exp_q.size() == 0) chk("unexpected_err", exp_q.size(), 1);
                else begin
                    mon_e = exp_q.pop_front();
                    chk("err_kind", bus.err_addr, mon_e.is_err);
                    chk("err_edge", cyc, mon_e.edge_n);
                end
            end
            if (!bus.nCS) begin
                if (mon_bits == 0) mon_start = cyc;
                mon_acc = {mon_acc[14:0], bus.COPI};
                mon_bits++;
            end else if (mon_bits != 0) begin
                chk("frame_len", mon_bits, 16);
                if (exp_q.size() == 0) chk("unexpected_frame", exp_q.size(), 1);
                else begin
                    mon_e = exp_q.pop_front();
                    chk("frame_kind", 32'(mon_e.is_err), 0);
                    chk("frame_bits", mon_acc, mon_e.frame);
                    chk("frame_start", mon_start, mon_e.edge_n);
                end
                last_frame = mon_acc;
                mon_bits = 0;
            end
        end
    end

    // GAP_CYCLES=1 instance: both requesters always valid.
    int   g1_prev_fall = -1, g1_high = 0, g1_checks = 0;
    logic g1_prev = 1'b1;
    always @(negedge SCLK) begin
        if (rst1_n) begin
            if (g1_prev && !bus1.nCS) begin
                if (g1_prev_fall >= 0 && g1_checks < 8) begin
                    chk("gap1_spacing", cyc - g1_prev_fall, 17);
                    chk("gap1_ncs_high", g1_high, 1);
                    g1_checks++;
                end
                g1_prev_fall = cyc;
            end
            g1_high = bus1.nCS ? g1_high + 1 : 0;
            g1_prev = bus1.nCS;
        end
    end

    initial begin
        rst_n  = 1'b1;
        rst1_n = 1'b1;
        set_req(1'b0, 1'b0, 7'd0, 8'd0);
        set_req(1'b1, 1'b0, 7'd0, 8'd0);
        bus1.req0_valid = 1'b1; bus1.req0_addr = 7'd1; bus1.req0_data = 8'h3C;
        bus1.req1_valid = 1'b1; bus1.req1_addr = 7'd4; bus1.req1_data = 8'hC3;
        #2;
        rst1_n = 1'b0;
        do_reset();
        rst1_n = 1'b1;

        // Single requester frame.
        mode = M_DROP;
        set_req(1'b0, 1'b1, 7'd2, 8'hA5);
        repeat (22) step();
        chk("frame_82A5", last_frame, 16'h82A5);

        // Contention from reset: req0 first, then req1.
        do_reset();
        set_req(1'b0, 1'b1, 7'd0, 8'h11);
        set_req(1'b1, 1'b1, 7'd4, 8'hFF);
        repeat (40) step();
        chk("frame_84FF", last_frame, 16'h84FF);

        // Reset in the middle of a frame; the held command is resent whole.
        do_reset();
        mode = M_HOLD;
        set_req(1'b0, 1'b1, 7'd3, 8'h5A);
        for (int i = 0; i < 5 && exp_q.size() == 0; i++) step();
        chk("hold_accepted", exp_q.size(), 1);
        repeat (8) step();
        do_reset();
        mode = M_DROP;
        repeat (22) step();
        chk("frame_835A", last_frame, 16'h835A);

        // Out-of-range req1 followed immediately by req0.
        set_req(1'b1, 1'b1, 7'd5, 8'h33);
        set_req(1'b0, 1'b1, 7'd1, 8'h80);
        repeat (22) step();
        chk("frame_8180", last_frame, 16'h8180);

        // Continuous contention, then random traffic.
        mode = M_CONT;
        new_cmd(1'b0, 1'b1);
        new_cmd(1'b1, 1'b1);
        repeat (80) step();
        mode = M_RAND;
        repeat (1500) step();

        // Drain.
        mode = M_DROP;
        set_req(1'b0, 1'b0, 7'd0, 8'd0);
        set_req(1'b1, 1'b0, 7'd0, 8'd0);
        repeat (25) step();
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("gap1_frames_seen", g1_checks, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
